fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the next-generation pipelined CPU, replacing the single-cycle PC-to-IM path. Owns the program counter, issues reads to the synchronous instruction memory and buffers returned instructions in a DEPTH-entry prefetch queue. Presents them to decode with a valid/ready handshake and supports branch/jump redirect with flush, plus sticky halt.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch stage.
// fetch_entry_t is the default-width layout; fetch_unit builds its own entry from its parameters.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 16;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush, wrap-around pointers and a count.
// The head entry is read combinationally from storage; a push at full is accepted only alongside a pop.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IM request/credit logic, prefetch queue, redirect flush and sticky halt.
// Define FETCH_BYPASS_EN to let a response reach decode in its arrival cycle when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [ADDR_W-1:0]          im_addr,
  output logic                       im_rd_en,
  input  logic [INSTR_W-1:0]         im_instr,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       hlt,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [INSTR_W-1:0]         id_instr,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [ADDR_W-1:0]          id_pc_inc,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              halt_q;
  logic              issue;
  logic              resp_valid;
  logic              bypass;
  logic              deq;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [OCC_W-1:0]  count;
  logic [OCC_W:0]    pending;
  entry_t            resp;
  entry_t            head;
  entry_t            sel;

  // Handshake: an instruction transfers on any cycle where id_valid && id_ready are both high;
  // id_* stay stable while id_valid is high and id_ready is low, except on a redirect flush.

  // A response arriving in a redirect cycle is stale and is simply not enqueued.
  assign resp_valid = inflight && !redirect;
  assign resp       = '{pc: inflight_pc, instr: im_instr};

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && resp_valid;
`else
  assign bypass = 1'b0;
`endif

  assign sel       = bypass ? resp : head;
  assign id_valid  = bypass || !fifo_empty;
  assign id_instr  = id_valid ? sel.instr : '0;
  assign id_pc     = id_valid ? sel.pc : '0;
  assign id_pc_inc = id_valid ? sel.pc + ADDR_W'(1) : '0;
  assign deq       = id_valid && id_ready;
  assign fifo_push = resp_valid && !(bypass && id_ready);
  assign fifo_pop  = deq && !bypass;

  // Credit: queued entries plus the outstanding response must leave room for the new one.
  assign pending  = {1'b0, count} + (OCC_W+1)'(inflight) - (OCC_W+1)'(deq);
  assign issue    = rst_n && !redirect && !hlt && !halt_q && (pending < (OCC_W+1)'(DEPTH));
  assign im_rd_en = issue;
  assign im_addr  = fetch_pc;

  assign halted    = halt_q && fifo_empty && !inflight;
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      if (hlt) halt_q <= 1'b1;
      if (redirect)   fetch_pc <= redirect_pc;
      else if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
    end
  end

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (OCC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (resp),
    .pop       (fifo_pop),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build, no bypass); IM model returns addr+0x1000.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_inc;
  logic        halted;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr),
    .im_rd_en    (im_rd_en),
    .im_instr    (im_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hlt         (hlt),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_inc   (id_pc_inc),
    .halted      (halted),
    .occupancy   (occupancy)
  );

  // Clock and instruction memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial im_instr = '0;
  always @(posedge clk) begin
    if (im_rd_en) im_instr <= im_addr + 16'h1000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_rd_en"},     32'(im_rd_en),  32'h0);
    check({p, "_im_addr"},   32'(im_addr),   32'h0);
    check({p, "_id_valid"},  32'(id_valid),  32'h0);
    check({p, "_id_instr"},  32'(id_instr),  32'h0);
    check({p, "_id_pc"},     32'(id_pc),     32'h0);
    check({p, "_id_pc_inc"}, 32'(id_pc_inc), 32'h0);
    check({p, "_halted"},    32'(halted),    32'h0);
    check({p, "_occ"},       32'(occupancy), 32'h0);
  endtask

  // Compare accepted PCs against base, base+1, ... (mod 2^16), then start a new segment.
  task automatic check_seq(input string tag, input logic [15:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(16'(base + 16'(i)));
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
  endtask

  // Monitor: every accepted instruction must carry its own IM data and pc+1.
  always @(negedge clk) begin
    if (id_valid && id_ready) begin
      check("acc_instr",  32'(id_instr),  32'(16'(id_pc + 16'h1000)));
      check("acc_pc_inc", 32'(id_pc_inc), 32'(16'(id_pc + 16'h0001)));
      got_q.push_back(id_pc);
    end
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    hlt         = 1'b0;
    id_ready    = 1'b0;

    repeat (3) tick();
    #1;
    check_reset_state("reset");

    // Stream from RESET_PC, one per cycle from cycle 2
    tick(); rst_n = 1'b1; id_ready = 1'b1; #1;
    check("c0_rd_en", 32'(im_rd_en), 32'h1);
    check("c0_addr",  32'(im_addr),  32'h0);
    tick(); #1;
    check("c1_valid", 32'(id_valid), 32'h0);
    check("c1_addr",  32'(im_addr),  32'h1);
    tick(); #1;
    check("c2_valid",  32'(id_valid),  32'h1);
    check("c2_pc",     32'(id_pc),     32'h0);
    check("c2_instr",  32'(id_instr),  32'h1000);
    check("c2_pc_inc", 32'(id_pc_inc), 32'h1);

    // Backpressure: queue fills to DEPTH and fetch stops
    repeat (5) tick();
    id_ready = 1'b0;
    repeat (9) tick();
    #1;
    check("stall_occ",   32'(occupancy), 32'h4);
    check("stall_rd_en", 32'(im_rd_en),  32'h0);
    check("stall_valid", 32'(id_valid),  32'h1);
    check("stall_pc",    32'(id_pc),     32'h5);
    tick(); id_ready = 1'b1;
    repeat (10) tick();

    // Redirect with 3 queued + 1 in flight; handshake in this cycle still counts
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    check("rd_pre_occ",   32'(occupancy), 32'h3);
    check("rd_pre_rd_en", 32'(im_rd_en),  32'h0);
    check("rd_pre_pc",    32'(id_pc),     32'hf);
    check_seq("stream", 16'h0000, 15);
    tick(); redirect = 1'b0; #1;
    check_seq("redir_pre", 16'h000f, 1);
    check("rd_n1_occ",   32'(occupancy), 32'h0);
    check("rd_n1_valid", 32'(id_valid),  32'h0);
    check("rd_n1_rd_en", 32'(im_rd_en),  32'h1);
    check("rd_n1_addr",  32'(im_addr),   32'h40);
    tick(); #1;
    check("rd_n2_valid", 32'(id_valid), 32'h0);
    tick(); #1;
    check("rd_n3_valid", 32'(id_valid), 32'h1);
    check("rd_n3_pc",    32'(id_pc),    32'h40);
    check("rd_n3_instr", 32'(id_instr), 32'h1040);
    repeat (4) tick();

    // PC wrap at 0xFFFF
    redirect = 1'b1; redirect_pc = 16'hfffe; id_ready = 1'b0; #1;
    check_seq("redir_post", 16'h0040, 4);
    tick(); redirect = 1'b0; id_ready = 1'b1; #1;
    check("wrap_addr0", 32'(im_addr), 32'hfffe);
    tick(); #1;
    check("wrap_addr1", 32'(im_addr), 32'hffff);
    tick(); #1;
    check("wrap_addr2", 32'(im_addr), 32'h0000);
    check("wrap_pc0",   32'(id_pc),   32'hfffe);
    tick(); #1;
    check("wrap_pc1",     32'(id_pc),     32'hffff);
    check("wrap_pc_inc1", 32'(id_pc_inc), 32'h0000);
    repeat (3) tick();

    // Halt with 3 queued + 1 in flight
    redirect = 1'b1; redirect_pc = 16'h0100; id_ready = 1'b0; #1;
    check_seq("wrap", 16'hfffe, 4);
    tick(); redirect = 1'b0;
    repeat (4) tick();
    hlt = 1'b1; id_ready = 1'b1; #1;
    check("h5_occ",    32'(occupancy), 32'h3);
    check("h5_rd_en",  32'(im_rd_en),  32'h0);
    check("h5_halted", 32'(halted),    32'h0);
    check("h5_pc",     32'(id_pc),     32'h100);
    tick(); hlt = 1'b0; #1;
    check("h6_rd_en", 32'(im_rd_en), 32'h0);
    tick(); #1;
    check("h7_rd_en", 32'(im_rd_en), 32'h0);
    tick(); #1;
    check("h8_halted", 32'(halted), 32'h0);
    tick(); #1;
    check("h9_halted", 32'(halted),   32'h1);
    check("h9_rd_en",  32'(im_rd_en), 32'h0);
    check("h9_valid",  32'(id_valid), 32'h0);
    check_seq("halt", 16'h0100, 4);
    tick(); redirect = 1'b1; redirect_pc = 16'h0200; #1;
    check("h10_rd_en", 32'(im_rd_en), 32'h0);
    tick(); redirect = 1'b0; #1;
    check("h11_rd_en",  32'(im_rd_en), 32'h0);
    check("h11_addr",   32'(im_addr),  32'h200);
    check("h11_halted", 32'(halted),   32'h1);
    repeat (2) tick(); #1;
    check("h13_halted", 32'(halted), 32'h1);

    // Reset clears halt; then reset again mid-stream
    rst_n = 1'b0; #1;
    check_reset_state("halt_rst");
    tick(); rst_n = 1'b1; id_ready = 1'b1;
    repeat (3) tick();
    check("pre_rst_valid", 32'(id_valid), 32'h1);
    rst_n = 1'b0; #1;
    check_reset_state("mid_rst");
    check_seq("pre_rst", 16'h0000, 1);
    tick(); rst_n = 1'b1; #1;
    check("refetch_rd_en", 32'(im_rd_en), 32'h1);
    check("refetch_addr",  32'(im_addr),  32'h0);
    tick(); tick(); #1;
    check("refetch_valid", 32'(id_valid), 32'h1);
    check("refetch_pc",    32'(id_pc),    32'h0);
    repeat (4) tick();
    check_seq("refetch", 16'h0000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
